benes_cfg_loader: RTL and testbench

//  Control-side writer for the 16x16 Benes network data path. Receives per-stage switch-setting

---
 rtl/benes_cfg_loader.sv | 99 +++++++++
 tb/tb_benes_cfg_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/benes_cfg_loader.sv
// Config-stream writer for the 16x16 Benes switch fabric: gathers one word per stage into a
// shadow bank and, once a well-framed frame completes, commits the whole bank to switch_set.
module benes_cfg_loader #(
  parameter int NUM_STAGES   = 7,
  parameter int SW_PER_STAGE = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [SW_PER_STAGE-1:0] cfg_data,
  input  logic                    cfg_last,
  input  logic                    cfg_abort,
  output logic [SW_PER_STAGE-1:0] switch_set [NUM_STAGES-1:0],
  output logic                    cfg_done,
  output logic                    cfg_err,
  output logic                    busy
);

  localparam int                CNT_W    = $clog2(NUM_STAGES);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [SW_PER_STAGE-1:0]   shadow [NUM_STAGES-1:0];
  logic                      accept;

  // Ready depends only on state and abort, never on cfg_valid.
  assign cfg_ready = (state != COMMIT) && !cfg_abort;
  assign accept    = cfg_valid && cfg_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        shadow[s]     <= '0;
        switch_set[s] <= '0;
      end
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_abort) begin
            cnt <= '0;
          end else if (accept) begin
            if (cfg_last) begin
              cfg_err <= 1'b1;
              cnt     <= '0;
            end else begin
              shadow[0] <= cfg_data;
              cnt       <= CNT_W'(1);
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (accept) begin
            // A frame is good only if cfg_last coincides exactly with the final stage word.
            if (cfg_last == (cnt == LAST_IDX)) begin
              shadow[cnt] <= cfg_data;
              if (cfg_last) begin
                state <= COMMIT;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end else begin
              cfg_err <= 1'b1;
              cnt     <= '0;
              state   <= IDLE;
            end
          end
        end
        COMMIT: begin
          for (int s = 0; s < NUM_STAGES; s++) begin
            switch_set[s] <= shadow[s];
          end
          cfg_done <= 1'b1;
          cnt      <= '0;
          state    <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_benes_cfg_loader.sv
// Bench for benes_cfg_loader: table-driven first frame, hand-written framing corner cases and
// a randomized run, all checked against a queue-based frame model.
module tb_benes_cfg_loader;
  localparam int NS = 7;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [SW-1:0] cfg_data;
  logic          cfg_last;
  logic          cfg_abort;
  logic [SW-1:0] switch_set [NS-1:0];
  logic          cfg_done;
  logic          cfg_err;
  logic          busy;

  always #5 clk = ~clk;

  benes_cfg_loader #(.NUM_STAGES(NS), .SW_PER_STAGE(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .cfg_abort  (cfg_abort),
    .switch_set (switch_set),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words of the open frame in a queue, plus a staged bank awaiting commit.
  logic [SW-1:0] m_frame [$];
  logic [SW-1:0] m_staged [NS];
  logic [SW-1:0] m_active [NS];
  bit            m_commit;
  bit            m_done;
  bit            m_err;

  logic [SW-1:0] fw [NS];
  bit            last_rdy;

  function automatic void m_reset();
    m_frame.delete();
    m_commit = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    for (int s = 0; s < NS; s++) begin
      m_active[s] = '0;
      m_staged[s] = '0;
    end
  endfunction

  function automatic bit m_ready(input bit a);
    return !m_commit && !a;
  endfunction

  function automatic bit m_busy();
    return m_commit || (m_frame.size() != 0);
  endfunction

  function automatic void m_step(input bit v, input logic [SW-1:0] d, input bit l,
                                 input bit a, input bit r);
    bit acc;
    acc    = v && m_ready(a);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (r) begin
      m_reset();
    end else if (m_commit) begin
      for (int s = 0; s < NS; s++) m_active[s] = m_staged[s];
      m_commit = 1'b0;
      m_done   = 1'b1;
      m_frame.delete();
    end else if (a) begin
      m_frame.delete();
    end else if (acc) begin
      if (l != (m_frame.size() == NS - 1)) begin
        m_err = 1'b1;
        m_frame.delete();
      end else begin
        m_frame.push_back(d);
        if (l) begin
          for (int s = 0; s < NS; s++) m_staged[s] = m_frame[s];
          m_commit = 1'b1;
          m_frame.delete();
        end
      end
    end
  endfunction

  function automatic logic [63:0] pack_dut();
    logic [63:0] p;
    p = '0;
    for (int s = 0; s < NS; s++) p[s*SW +: SW] = switch_set[s];
    return p;
  endfunction

  function automatic logic [63:0] pack_model();
    logic [63:0] p;
    p = '0;
    for (int s = 0; s < NS; s++) p[s*SW +: SW] = m_active[s];
    return p;
  endfunction

  function automatic logic [63:0] pack_fill(input logic [SW-1:0] w);
    logic [63:0] p;
    p = '0;
    for (int s = 0; s < NS; s++) p[s*SW +: SW] = w;
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check ready before the edge, advance model, check registered outputs.
  task automatic step(input bit v, input logic [SW-1:0] d, input bit l, input bit a, input bit r);
    cfg_valid = v;
    cfg_data  = d;
    cfg_last  = l;
    cfg_abort = a;
    rst       = r;
    #1;
    last_rdy = cfg_ready;
    chk("ready", cfg_ready, m_ready(a));
    @(posedge clk);
    m_step(v, d, l, a, r);
    #1;
    chk("done", cfg_done, m_done);
    chk("err", cfg_err, m_err);
    chk("busy", busy, m_busy());
    chk("switch_set", pack_dut(), pack_model());
  endtask

  task automatic send_words(input int n, input int last_idx, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) step(1'b0, SW'($urandom), 1'b0, 1'b0, 1'b0);
      end
      step(1'b1, fw[i], (i == last_idx), 1'b0, 1'b0);
    end
  endtask

  task automatic fill(input logic [SW-1:0] w);
    for (int s = 0; s < NS; s++) fw[s] = w;
  endtask

  typedef struct {
    bit            v;
    logic [SW-1:0] d;
    bit            l;
    bit            e_rdy;
    bit            e_done;
    bit            e_err;
    bit            e_busy;
  } vec_t;

  vec_t tbl [NS + 2];

  initial begin
    bit got;

    // Test 1 vectors: 7 one-hot words, then the COMMIT cycle, then idle.
    for (int i = 0; i < NS; i++) tbl[i] = '{1'b1, SW'(1 << i), (i == NS - 1), 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[NS]     = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[NS + 1] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; cfg_abort = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("reset_switch", pack_dut(), 64'h0);
    chk("reset_busy", busy, 1'b0);

    for (int i = 0; i < NS + 2; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, 1'b0, 1'b0);
      chk($sformatf("t1_rdy[%0d]", i), last_rdy, tbl[i].e_rdy);
      chk($sformatf("t1_done[%0d]", i), cfg_done, tbl[i].e_done);
      chk($sformatf("t1_err[%0d]", i), cfg_err, tbl[i].e_err);
      chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].e_busy);
    end
    chk("t1_onehot", pack_dut(), 64'h0040_2010_0804_0201);

    // Test 2: same frame with random bubbles after a fresh reset.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < NS; i++) fw[i] = SW'(1 << i);
    send_words(NS, NS - 1, 1'b1);
    chk("t2_pre_commit", pack_dut(), 64'h0);
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      got = cfg_done;
    end
    chk("t2_done_seen", got, 1'b1);
    chk("t2_onehot", pack_dut(), 64'h0040_2010_0804_0201);

    // Test 3: commit all-FF, then early last, then good frame A5.
    fill(8'hFF);
    send_words(NS, NS - 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_ff", pack_dut(), pack_fill(8'hFF));
    fill(8'h77);
    send_words(3, 2, 1'b0);
    chk("t3_early_err", cfg_err, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_err_pulse", cfg_err, 1'b0);
    chk("t3_keep_ff", pack_dut(), pack_fill(8'hFF));
    fill(8'hA5);
    send_words(NS, NS - 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t3_done", cfg_done, 1'b1);
    chk("t3_a5", pack_dut(), pack_fill(8'hA5));

    // Test 4: missing last on the final word.
    fill(8'h3E);
    send_words(NS, -1, 1'b0);
    chk("t4_err", cfg_err, 1'b1);
    chk("t4_idle", busy, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_no_done", cfg_done, 1'b0);
    chk("t4_keep", pack_dut(), pack_fill(8'hA5));

    // Test 5: abort with valid after 4 words, then a good frame.
    fill(8'h12);
    send_words(4, -1, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("t5_ready_low", last_rdy, 1'b0);
    chk("t5_no_err", cfg_err, 1'b0);
    chk("t5_busy_drop", busy, 1'b0);
    fill(8'h5A);
    send_words(NS, NS - 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t5_done", cfg_done, 1'b1);
    chk("t5_5a", pack_dut(), pack_fill(8'h5A));

    // Test 6: reset during COMMIT, then back-to-back frames.
    fill(8'h3C);
    send_words(NS, NS - 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_switch", pack_dut(), 64'h0);
    chk("t6_rst_no_done", cfg_done, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_still_no_done", cfg_done, 1'b0);
    fill(8'h11);
    send_words(NS, NS - 1, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    chk("b2b_commit_stall", last_rdy, 1'b0);
    chk("b2b_done", cfg_done, 1'b1);
    fill(8'h22);
    send_words(NS, NS - 1, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("b2b_22", pack_dut(), pack_fill(8'h22));

    // Randomized run against the model.
    for (int c = 0; c < 800; c++) begin
      bit v, l, a, r;
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 149) == 0);
      if (m_frame.size() == NS - 1) l = ($urandom_range(0, 7) != 0);
      else                          l = ($urandom_range(0, 19) == 0);
      step(v, SW'($urandom), l, a, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
